// File: rtl/alu_seq_pkg.sv
// Shared definitions for the nibble-serial ALU controller and its 4-bit ALU slice.
package alu_seq_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam logic [1:0] FN_AND  = 2'b00;
  localparam logic [1:0] FN_OR   = 2'b01;
  localparam logic [1:0] FN_ADD  = 2'b10;
  localparam logic [1:0] FN_LESS = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_SLTFIX = 2'b10,
    S_DONE   = 2'b11
  } state_e;

  function automatic logic op_legal(logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_SLT);
  endfunction

  function automatic logic op_inverts_b(logic [2:0] op);
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction

  function automatic logic [1:0] fn_sel(logic [2:0] op);
    case (op)
      OP_AND:  return FN_AND;
      OP_OR:   return FN_OR;
      default: return FN_ADD;
    endcase
  endfunction

endpackage

// File: rtl/alu_4bit.sv
// MIPS-style 4-bit ALU slice: AND / OR / add with optional B inversion / pass-through of less.
module alu_4bit
  import alu_seq_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       binv,
  input  logic       cin,
  input  logic       less,
  input  logic       sel1,
  input  logic       sel0,
  output logic [3:0] result,
  output logic       co
);

  logic [3:0] b_eff;
  logic [4:0] sum;

  assign b_eff = b ^ {4{binv}};
  assign sum   = {1'b0, a} + {1'b0, b_eff} + {4'b0000, cin};
  assign co    = sum[4];

  always_comb begin
    case ({sel1, sel0})
      FN_AND:  result = a & b_eff;
      FN_OR:   result = a | b_eff;
      FN_ADD:  result = sum[3:0];
      default: result = {3'b000, less};
    endcase
  end

endmodule

// File: rtl/alu_nibble_seq.sv
// Runs a W-bit ALU operation through one shared alu_4bit, one nibble per clock, LSB first,
// with a start/busy/done handshake and a set-on-less-than fix-up pass.
module alu_nibble_seq
  import alu_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [2:0]             op,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   co,
  output logic                   ovf,
  output logic                   zero,
  output logic                   err
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, b_q;
  logic [2:0]      op_q;
  logic [CW-1:0]   cnt_q;
  logic            carry_q;
  logic            accept;
  logic            last;
  logic            is_logic;
  logic            binv;
  logic [1:0]      fn;
  logic [CW+1:0]   nib_lo;
  logic [3:0]      alu_res;
  logic            alu_co;
  logic            ovf_calc;

  assign last     = (cnt_q == CW'(NIBBLES - 1));
  assign is_logic = (op_q == OP_AND) || (op_q == OP_OR);
  assign binv     = op_inverts_b(op_q);
  assign fn       = fn_sel(op_q);
  assign nib_lo   = {cnt_q, 2'b00};
  assign ovf_calc = (a_q[W-1] == (b_q[W-1] ^ binv)) && (alu_res[3] != a_q[W-1]);

  alu_4bit u_alu (
    .a      (a_q[nib_lo +: 4]),
    .b      (b_q[nib_lo +: 4]),
    .binv   (binv),
    .cin    (carry_q),
    .less   (1'b0),
    .sel1   (fn[1]),
    .sel0   (fn[0]),
    .result (alu_res),
    .co     (alu_co)
  );

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        done = (state_q == S_DONE);
        if (start) begin
          accept  = 1'b1;
          state_d = op_legal(op) ? S_RUN : S_DONE;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (last) state_d = (op_q == OP_SLT) ? S_SLTFIX : S_DONE;
      end
      S_SLTFIX: begin
        busy    = 1'b1;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_AND;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      result  <= '0;
      co      <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b1;
      err     <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            if (op_legal(op)) begin
              a_q     <= a;
              b_q     <= b;
              op_q    <= op;
              cnt_q   <= '0;
              carry_q <= op_inverts_b(op);
            end else begin
              result <= '0;
              co     <= 1'b0;
              ovf    <= 1'b0;
              zero   <= 1'b1;
              err    <= 1'b1;
            end
          end
        end
        S_RUN: begin
          result[nib_lo +: 4] <= alu_res;
          carry_q             <= is_logic ? 1'b0 : alu_co;
          cnt_q               <= cnt_q + 1'b1;
          if (last) begin
            co   <= is_logic ? 1'b0 : alu_co;
            ovf  <= is_logic ? 1'b0 : ovf_calc;
            err  <= 1'b0;
            zero <= (alu_res == 4'h0) && (result[W-5:0] == '0);
          end
        end
        S_SLTFIX: begin
          // The sign of the difference, corrected by overflow, is the less-than answer.
          result <= {{(W-1){1'b0}}, result[W-1] ^ ovf};
          zero   <= ~(result[W-1] ^ ovf);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Self-checking bench for alu_nibble_seq: directed vector table, handshake/reset sequences,
// and randomized operations against an arithmetic reference model.
module tb_alu_nibble_seq;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, co, ovf, zero, err;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;

  alu_nibble_seq #(.NIBBLES(NIB)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .co     (co),
    .ovf    (ovf),
    .zero   (zero),
    .err    (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         co;
    logic         ovf;
    logic         zero;
    logic         err;
    int           lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the full-width operands.
  function automatic vec_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    vec_t   v;
    longint sx, sy, sr;
    longint unsigned ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'(x);
    uy = longint'(y);
    v.op = o; v.a = x; v.b = y;
    v.co = 1'b0; v.ovf = 1'b0; v.err = 1'b0; v.lat = NIB + 1;
    case (o)
      3'b000: v.res = x & y;
      3'b001: v.res = x | y;
      3'b010: begin
        v.res = x + y;
        v.co  = ((ux + uy) >> W) != 0;
        sr    = sx + sy;
        v.ovf = (sr > 32767) || (sr < -32768);
      end
      3'b110, 3'b111: begin
        v.co  = (ux >= uy);
        sr    = sx - sy;
        v.ovf = (sr > 32767) || (sr < -32768);
        if (o == 3'b110) v.res = x - y;
        else begin
          v.res = (sx < sy) ? W'(1) : W'(0);
          v.lat = NIB + 2;
        end
      end
      default: begin
        v.res = '0;
        v.err = 1'b1;
        v.lat = 1;
      end
    endcase
    v.zero = (v.res == '0);
    return v;
  endfunction

  // Drives one start and waits (bounded) for done. If pulse_at > 0, start is raised again
  // with different operands for the edge after sample pulse_at.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int pulse_at, output vec_t got, output int busy_n);
    int edges;
    edges  = 0;
    busy_n = 0;
    got    = '{default: '0};
    got.lat = -1;
    op = o; a = x; b = y; start = 1'b1;
    while (edges < 12) begin
      @(posedge clk); #1;
      edges++;
      if (busy) busy_n++;
      if (done) begin
        got.res = result; got.co = co; got.ovf = ovf;
        got.zero = zero; got.err = err; got.lat = edges;
        break;
      end
      if (edges == pulse_at) begin
        start = 1'b1; op = 3'b110; a = ~x; b = ~y;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic compare(input string tag, input vec_t e, input vec_t g, input int busy_n);
    check({tag, " result"}, 32'(g.res), 32'(e.res));
    check({tag, " co"},     32'(g.co),  32'(e.co));
    check({tag, " ovf"},    32'(g.ovf), 32'(e.ovf));
    check({tag, " zero"},   32'(g.zero), 32'(e.zero));
    check({tag, " err"},    32'(g.err), 32'(e.err));
    check({tag, " latency"}, 32'(g.lat), 32'(e.lat));
    check({tag, " busy cycles"}, 32'(busy_n), 32'(e.err ? 0 : e.lat - 1));
  endtask

  vec_t tbl [12];
  vec_t got, exp;
  int   busy_n;
  int   done_seen;

  initial begin
    tbl[0]  = '{3'b010, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0, 1'b0, 1'b0, 5};
    tbl[1]  = '{3'b110, 16'h0005, 16'h0006, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 5};
    tbl[2]  = '{3'b110, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0, 5};
    tbl[3]  = '{3'b110, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 5};
    tbl[4]  = '{3'b111, 16'hFFFE, 16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 6};
    tbl[5]  = '{3'b111, 16'h7FFF, 16'h8000, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 6};
    tbl[6]  = '{3'b000, 16'hF0F0, 16'h5555, 16'h5050, 1'b0, 1'b0, 1'b0, 1'b0, 5};
    tbl[7]  = '{3'b001, 16'hF0F0, 16'h5555, 16'hF5F5, 1'b0, 1'b0, 1'b0, 1'b0, 5};
    tbl[8]  = '{3'b011, 16'hABCD, 16'h1111, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1};
    tbl[9]  = '{3'b010, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 5};
    tbl[10] = '{3'b010, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 5};
    tbl[11] = '{3'b100, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1};

    repeat (2) @(posedge clk);
    #1;
    check("reset busy",   32'(busy),   32'd0);
    check("reset done",   32'(done),   32'd0);
    check("reset result", 32'(result), 32'd0);
    check("reset zero",   32'(zero),   32'd1);
    check("reset err",    32'(err),    32'd0);
    check("reset co/ovf", 32'({co, ovf}), 32'd0);
    rst_n = 1'b1;

    // Back-to-back: each start after the first lands in the DONE cycle of the previous op.
    for (int i = 0; i < 12; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, 0, got, busy_n);
      compare($sformatf("vec%0d", i), tbl[i], got, busy_n);
    end

    // start re-pulsed mid-RUN with new operands is ignored
    repeat (2) @(posedge clk);
    #1;
    run_op(3'b010, 16'h1234, 16'h0FFF, 2, got, busy_n);
    compare("repulse", tbl[0], got, busy_n);
    @(posedge clk); #1;
    check("repulse no second done", 32'(done), 32'd0);

    // reset while the nibble counter is 2
    op = 3'b010; a = 16'h1234; b = 16'h0FFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrun reset busy",   32'(busy),   32'd0);
    check("midrun reset result", 32'(result), 32'd0);
    check("midrun reset zero",   32'(zero),   32'd1);
    done_seen = 0;
    repeat (8) begin
      if (done) done_seen++;
      @(posedge clk); #1;
    end
    check("midrun reset no done", 32'(done_seen), 32'd0);
    run_op(3'b110, 16'h8000, 16'h0001, 0, got, busy_n);
    compare("after reset", tbl[2], got, busy_n);

    // randomized operations with idle gaps
    for (int i = 0; i < 150; i++) begin
      logic [2:0]   o;
      logic [W-1:0] x, y;
      int           gap;
      case ($urandom_range(0, 5))
        0: o = 3'b000;
        1: o = 3'b001;
        2: o = 3'b010;
        3: o = 3'b110;
        4: o = 3'b111;
        default: o = 3'($urandom_range(3, 5));
      endcase
      x = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 1) ? 16'h8000 : 16'h7FFF) : W'($urandom);
      y = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 1) ? 16'hFFFF : 16'h0000) : W'($urandom);
      exp = model(o, x, y);
      run_op(o, x, y, 0, got, busy_n);
      compare($sformatf("rand%0d", i), exp, got, busy_n);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
        check($sformatf("rand%0d idle done", i), 32'(done), 32'd0);
        check($sformatf("rand%0d held result", i), 32'(result), 32'(exp.res));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
